// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 field widths, special encodings and rounding-mode type
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = FRAC_W + 1;
   localparam int PROD_W = 2 * MANT_W;
   localparam int EXPI_W = EXP_W + 2;
   localparam int BIAS   = 127;

   localparam logic [EXP_W-1:0]  EXP_ALL1 = 8'hFF;
   localparam logic [EXP_W-1:0]  EXP_MAXF = 8'hFE;
   localparam logic [FRAC_W-1:0] FRAC_ALL1 = 23'h7FFFFF;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;
   localparam logic [31:0] MAX_FIN = 32'h7F7FFFFF;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } rmode_e;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   // Unassigned encodings 5..7 fall back to round-to-nearest-even.
   function automatic rmode_e decode_rmode(input logic [2:0] raw);
      rmode_e mode;
      case (raw)
         3'd1:    mode = RTZ;
         3'd2:    mode = RDN;
         3'd3:    mode = RUP;
         3'd4:    mode = RMM;
         default: mode = RNE;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/fp32_round.sv
// rtl/fp32_round.sv - rounds a normalized 24-bit mantissa and resolves overflow/underflow
module fp32_round
   import fp32_pkg::*;
(
   input  logic                     i_sign,
   input  logic [MANT_W-1:0]        i_mant,
   input  logic                     i_g,
   input  logic                     i_r,
   input  logic                     i_s,
   input  logic signed [EXPI_W-1:0] i_exp,
   input  rmode_e                   i_mode,
   output logic [EXP_W-1:0]         o_exp,
   output logic [FRAC_W-1:0]        o_frac,
   output logic                     o_ovf,
   output logic                     o_udf
);

   logic                     w_any;
   logic                     w_inc;
   logic [MANT_W:0]          w_sum;
   logic [MANT_W-1:0]        w_mant_r;
   logic signed [EXPI_W-1:0] w_exp_r;
   logic                     w_to_inf;

   always_comb begin
      w_any = i_g | i_r | i_s;
      case (i_mode)
         RNE:     w_inc = i_g & (i_r | i_s | i_mant[0]);
         RTZ:     w_inc = 1'b0;
         RDN:     w_inc = i_sign & w_any;
         RUP:     w_inc = ~i_sign & w_any;
         RMM:     w_inc = i_g;
         default: w_inc = i_g & (i_r | i_s | i_mant[0]);
      endcase
   end

   // A carry out of the mantissa can only come from all-ones + 1, i.e. exactly 2.0.
   always_comb begin
      w_sum = {1'b0, i_mant} + {{MANT_W{1'b0}}, w_inc};
      if (w_sum[MANT_W]) begin
         w_mant_r = w_sum[MANT_W:1];
         w_exp_r  = i_exp + 10'sd1;
      end else begin
         w_mant_r = w_sum[MANT_W-1:0];
         w_exp_r  = i_exp;
      end
   end

   always_comb begin
      case (i_mode)
         RNE, RMM: w_to_inf = 1'b1;
         RUP:      w_to_inf = ~i_sign;
         RDN:      w_to_inf = i_sign;
         default:  w_to_inf = 1'b0;
      endcase
   end

   always_comb begin
      o_ovf  = 1'b0;
      o_udf  = 1'b0;
      o_exp  = w_exp_r[EXP_W-1:0];
      o_frac = w_mant_r[FRAC_W-1:0];
      if (w_exp_r >= 10'sd255) begin
         o_ovf  = 1'b1;
         o_exp  = w_to_inf ? EXP_ALL1 : EXP_MAXF;
         o_frac = w_to_inf ? '0 : FRAC_ALL1;
      end else if (w_exp_r <= 10'sd0) begin
         o_udf  = 1'b1;
         o_exp  = '0;
         o_frac = '0;
      end
   end

endmodule

// File: rtl/fp_mul32_ieee.sv
// rtl/fp_mul32_ieee.sv - binary32 multiplier, combinational datapath with registered result and flags
module fp_mul32_ieee
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  r_mode,
   input  logic [31:0] fp_X,
   input  logic [31:0] fp_Y,
   output logic [31:0] fp_Z,
   output logic        ovrf,
   output logic        udrf
);

   fp32_t  w_x;
   fp32_t  w_y;
   rmode_e w_mode;
   logic   w_sign;

   assign w_x    = fp_X;
   assign w_y    = fp_Y;
   assign w_mode = decode_rmode(r_mode);
   assign w_sign = w_x.sign ^ w_y.sign;

   // Subnormal inputs count as zero: the datapath is flush-to-zero.
   logic w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
   assign w_x_zero = (w_x.exp == '0);
   assign w_y_zero = (w_y.exp == '0);
   assign w_x_inf  = (w_x.exp == EXP_ALL1) && (w_x.frac == '0);
   assign w_y_inf  = (w_y.exp == EXP_ALL1) && (w_y.frac == '0);
   assign w_x_nan  = (w_x.exp == EXP_ALL1) && (w_x.frac != '0);
   assign w_y_nan  = (w_y.exp == EXP_ALL1) && (w_y.frac != '0);

   logic [MANT_W-1:0]        w_mx;
   logic [MANT_W-1:0]        w_my;
   logic [PROD_W-1:0]        w_prod;
   logic signed [EXPI_W-1:0] w_exp_base;

   assign w_mx       = {1'b1, w_x.frac};
   assign w_my       = {1'b1, w_y.frac};
   assign w_prod     = {{MANT_W{1'b0}}, w_mx} * {{MANT_W{1'b0}}, w_my};
   assign w_exp_base = signed'({2'b00, w_x.exp}) + signed'({2'b00, w_y.exp}) - 10'sd127;

   logic [MANT_W-1:0]        w_norm_mant;
   logic                     w_g, w_r, w_s;
   logic signed [EXPI_W-1:0] w_norm_exp;

   // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the extra shift.
   always_comb begin
      if (w_prod[PROD_W-1]) begin
         w_norm_mant = w_prod[47:24];
         w_g         = w_prod[23];
         w_r         = w_prod[22];
         w_s         = |w_prod[21:0];
         w_norm_exp  = w_exp_base + 10'sd1;
      end else begin
         w_norm_mant = w_prod[46:23];
         w_g         = w_prod[22];
         w_r         = w_prod[21];
         w_s         = |w_prod[20:0];
         w_norm_exp  = w_exp_base;
      end
   end

   logic [EXP_W-1:0]  w_rnd_exp;
   logic [FRAC_W-1:0] w_rnd_frac;
   logic              w_rnd_ovf;
   logic              w_rnd_udf;

   fp32_round u_round (
      .i_sign (w_sign),
      .i_mant (w_norm_mant),
      .i_g    (w_g),
      .i_r    (w_r),
      .i_s    (w_s),
      .i_exp  (w_norm_exp),
      .i_mode (w_mode),
      .o_exp  (w_rnd_exp),
      .o_frac (w_rnd_frac),
      .o_ovf  (w_rnd_ovf),
      .o_udf  (w_rnd_udf)
   );

   logic [31:0] w_z_next;
   logic        w_ovf_next;
   logic        w_udf_next;

   // Specials take priority over the arithmetic path and never raise flags.
   always_comb begin
      w_z_next   = '0;
      w_ovf_next = 1'b0;
      w_udf_next = 1'b0;
      if (w_x_nan || w_y_nan || (w_x_inf && w_y_zero) || (w_y_inf && w_x_zero)) begin
         w_z_next = QNAN;
      end else if (w_x_inf || w_y_inf) begin
         w_z_next = {w_sign, POS_INF[30:0]};
      end else if (w_x_zero || w_y_zero) begin
         w_z_next = {w_sign, 31'h0};
      end else begin
         w_z_next   = {w_sign, w_rnd_exp, w_rnd_frac};
         w_ovf_next = w_rnd_ovf;
         w_udf_next = w_rnd_udf;
      end
   end

   logic [31:0] r_z;
   logic        r_ovf;
   logic        r_udf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z   <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_z   <= w_z_next;
         r_ovf <= w_ovf_next;
         r_udf <= w_udf_next;
      end
   end

   assign fp_Z = r_z;
   assign ovrf = r_ovf;
   assign udrf = r_udf;

endmodule

// File: tb/tb_fp_mul32_ieee.sv
// tb/tb_fp_mul32_ieee.sv - directed and random checks of fp_mul32_ieee against an integer reference model
module tb_fp_mul32_ieee;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  r_mode;
   logic [31:0] fp_X;
   logic [31:0] fp_Y;
   logic [31:0] fp_Z;
   logic        ovrf;
   logic        udrf;

   int          checks = 0;
   int          failures = 0;
   logic [33:0] prev_res;

   fp_mul32_ieee dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .r_mode (r_mode),
      .fp_X   (fp_X),
      .fp_Y   (fp_Y),
      .fp_Z   (fp_Z),
      .ovrf   (ovrf),
      .udrf   (udrf)
   );

   always #5 clk = ~clk;

   // Returns {ovrf, udrf, fp_Z}; rounding decided by comparing the discarded remainder to one half.
   function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
      logic            sz;
      logic            up;
      logic            to_inf;
      int              ex, ey, e, sh, mode;
      longint unsigned mx, my, p, keep, rem, half;
      sz   = x[31] ^ y[31];
      ex   = {24'b0, x[30:23]};
      ey   = {24'b0, y[30:23]};
      mode = (m > 3'd4) ? 0 : {29'b0, m};
      if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0))
         return {2'b00, 32'h7FC00000};
      if (ex == 255 || ey == 255) begin
         if (ex == 0 || ey == 0)
            return {2'b00, 32'h7FC00000};
         return {2'b00, sz, 8'hFF, 23'h0};
      end
      if (ex == 0 || ey == 0)
         return {2'b00, sz, 31'h0};
      mx = 64'({1'b1, x[22:0]});
      my = 64'({1'b1, y[22:0]});
      p  = mx * my;
      e  = ex + ey - 127;
      if (p >= 64'h0000_8000_0000_0000) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      keep = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      case (mode)
         0:       up = (rem > half) || (rem == half && keep[0]);
         1:       up = 1'b0;
         2:       up = sz && (rem != 0);
         3:       up = !sz && (rem != 0);
         default: up = (rem >= half);
      endcase
      keep = keep + 64'(up);
      if (keep == (64'd1 << 24)) begin
         keep = 64'd1 << 23;
         e    = e + 1;
      end
      if (e >= 255) begin
         to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !sz) || (mode == 2 && sz);
         return to_inf ? {2'b10, sz, 8'hFF, 23'h0} : {2'b10, sz, 8'hFE, 23'h7FFFFF};
      end
      if (e <= 0)
         return {2'b01, sz, 31'h0};
      return {2'b00, sz, e[7:0], keep[22:0]};
   endfunction

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed={ovrf,udrf,fp_Z}=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called just after a rising edge: outputs must hold the previous result until the next edge.
   task automatic step(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
      logic [33:0] e;
      fp_X   = x;
      fp_Y   = y;
      r_mode = m;
      e      = ref_mul(x, y, m);
      #1;
      check({tag, "/hold"}, {ovrf, udrf, fp_Z}, prev_res);
      @(posedge clk);
      #1;
      check(tag, {ovrf, udrf, fp_Z}, e);
      prev_res = e;
   endtask

   task automatic gen_pair(output logic [31:0] x, output logic [31:0] y);
      logic [31:0] rx, ry;
      logic [31:0] tx, ty;
      int          ex, ey;
      rx = $urandom;
      ry = $urandom;
      ex = int'($urandom_range(1, 254));
      case ($urandom_range(0, 5))
         0:       ey = int'($urandom_range(0, 255));
         1:       ey = 127 - ex + int'($urandom_range(0, 3));
         2:       ey = 380 - ex + int'($urandom_range(0, 3));
         3:       ey = ($urandom_range(0, 1) != 0) ? 0 : 255;
         default: ey = int'($urandom_range(120, 134));
      endcase
      if (ey < 0)
         ey = 0;
      if (ey > 255)
         ey = 255;
      if ($urandom_range(0, 1) != 0) begin
         rx[22:0] = rx[22:0] & 23'h7FF800;
         ry[22:0] = ry[22:0] & 23'h7FF800;
      end
      tx = ex;
      ty = ey;
      x  = {rx[31], tx[7:0], rx[22:0]};
      y  = {ry[31], ty[7:0], ry[22:0]};
   endtask

   initial begin
      logic [31:0] x, y;
      logic [2:0]  m;
      rst_n    = 1'b0;
      r_mode   = 3'd0;
      fp_X     = 32'h0;
      fp_Y     = 32'h0;
      prev_res = '0;

      #3;
      check("reset_async", {ovrf, udrf, fp_Z}, 34'h0);
      #9;
      check("reset_held_over_edge", {ovrf, udrf, fp_Z}, 34'h0);
      rst_n = 1'b1;

      step("basic",      32'h40B00000, 32'hC0100000, 3'd0);
      check("basic_const", {ovrf, udrf, fp_Z}, {2'b00, 32'hC1460000});

      step("ovf_rne",    32'hF2A37F9E, 32'h6F18DA51, 3'd0);
      check("ovf_rne_const", {ovrf, udrf, fp_Z}, {2'b10, 32'hFF800000});
      step("ovf_rtz",    32'hF2A37F9E, 32'h6F18DA51, 3'd1);
      check("ovf_rtz_const", {ovrf, udrf, fp_Z}, {2'b10, 32'hFF7FFFFF});
      step("ovf_rup",    32'hF2A37F9E, 32'h6F18DA51, 3'd3);
      check("ovf_rup_const", {ovrf, udrf, fp_Z}, {2'b10, 32'hFF7FFFFF});
      step("ovf_rdn",    32'hF2A37F9E, 32'h6F18DA51, 3'd2);
      check("ovf_rdn_const", {ovrf, udrf, fp_Z}, {2'b10, 32'hFF800000});

      step("rnd_rne",    32'h3F800001, 32'h3F800001, 3'd0);
      check("rnd_rne_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h3F800002});
      step("rnd_rtz",    32'h3F800001, 32'h3F800001, 3'd1);
      check("rnd_rtz_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h3F800002});
      step("rnd_rdn",    32'h3F800001, 32'h3F800001, 3'd2);
      check("rnd_rdn_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h3F800002});
      step("rnd_rup",    32'h3F800001, 32'h3F800001, 3'd3);
      check("rnd_rup_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h3F800003});
      step("rnd_rmm",    32'h3F800001, 32'h3F800001, 3'd4);
      check("rnd_rmm_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h3F800002});
      step("rnd_mode7",  32'h3F800001, 32'h3F800001, 3'd7);
      check("rnd_mode7_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h3F800002});

      step("udf_pos",    32'h00800000, 32'h3F000000, 3'd0);
      check("udf_pos_const", {ovrf, udrf, fp_Z}, {2'b01, 32'h00000000});
      step("udf_neg",    32'h00800000, 32'hBF000000, 3'd0);
      check("udf_neg_const", {ovrf, udrf, fp_Z}, {2'b01, 32'h80000000});

      step("sp_zero",    32'h00000000, 32'h40B00000, 3'd0);
      check("sp_zero_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h00000000});
      step("sp_infzero", 32'h7F800000, 32'h00000000, 3'd0);
      check("sp_infzero_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h7FC00000});
      step("sp_inf",     32'h7F800000, 32'hC0000000, 3'd0);
      check("sp_inf_const", {ovrf, udrf, fp_Z}, {2'b00, 32'hFF800000});
      step("sp_nan",     32'h7FC00000, 32'h3F800000, 3'd0);
      check("sp_nan_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h7FC00000});
      step("sp_subn",    32'h80000001, 32'h3F800000, 3'd3);
      step("carry_ovf",  32'h7F7FFFFF, 32'h3F800001, 3'd1);

      for (int i = 0; i < 600; i++) begin
         gen_pair(x, y);
         m = 3'($urandom_range(0, 7));
         step("rand", x, y, m);
      end

      fp_X   = 32'h40400000;
      fp_Y   = 32'h40400000;
      r_mode = 3'd0;
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_midstream", {ovrf, udrf, fp_Z}, 34'h0);
      @(posedge clk);
      #1;
      check("reset_mid_edge", {ovrf, udrf, fp_Z}, 34'h0);
      #1;
      rst_n    = 1'b1;
      prev_res = '0;
      step("post_reset", 32'h40400000, 32'h40400000, 3'd0);
      check("post_reset_const", {ovrf, udrf, fp_Z}, {2'b00, 32'h41100000});
      for (int i = 0; i < 20; i++) begin
         gen_pair(x, y);
         m = 3'($urandom_range(0, 4));
         step("rand_post", x, y, m);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_mul32_ieee.md
Name: fp_mul32_ieee

Overview:
- Single-precision (IEEE-754 binary32) floating-point multiplier with five selectable rounding modes.
- Computes fp_Z = fp_X × fp_Y and raises overflow/underflow flags.
- Datapath is combinational; the result and flags are registered, giving 1-cycle latency.
- Standalone arithmetic leaf used by the FP datapath; no handshake, a new operand pair may be applied every cycle.

Parameters:
- none (binary32 format fixed)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- r_mode  in  3  rounding mode: 0 RNE (nearest, ties-to-even), 1 RTZ, 2 RDN (toward −inf), 3 RUP (toward +inf), 4 RMM (nearest, ties-away); 5–7 treated as 0
- fp_X  in  32  operand A, binary32
- fp_Y  in  32  operand B, binary32
- fp_Z  out  32  registered product, binary32
- ovrf  out  1  registered overflow flag for fp_Z
- udrf  out  1  registered underflow flag for fp_Z

Behaviour:
- Reset: rst_n low asynchronously clears fp_Z=0x00000000, ovrf=0, udrf=0. Outputs stay cleared until the first rising edge after rst_n deasserts.
- Latency: operands and r_mode sampled at rising edge N produce fp_Z/ovrf/udrf visible after edge N. Full throughput, one result per cycle.
- Sign: sZ = sX XOR sY, applied to every result including zero, inf and overflow/underflow outputs, but not NaN.
- Specials (checked first, flags 0):
  - exp=0xFF with mant≠0 on either input → 0x7FC00000.
  - inf × zero → 0x7FC00000.
  - inf × finite nonzero → ±inf (sZ,0xFF,0).
  - Inputs with exp=0 (zero or subnormal) are treated as zero (flush-to-zero) → ±0, flags 0.
- Normal path:
  - mX={1,fracX}, mY={1,fracY}; 48-bit product P=mX*mY.
  - Biased exponent E=eX+eY−127.
  - If P[47]=1, shift right 1 and E+=1.
  - Mantissa = 24 MSBs of the normalized product. Guard = next bit; round = bit after; sticky = OR of the rest.
- Rounding increment:
  - RNE: G & (R|S|LSB).
  - RTZ: never.
  - RDN: sZ & (G|R|S).
  - RUP: ~sZ & (G|R|S).
  - RMM: G.
  - A mantissa carry-out renormalizes (mant=1.0, E+=1).
- Overflow (E≥255 after rounding): ovrf=1, udrf=0.
  - Result ±inf for RNE/RMM, for RUP when positive, and for RDN when negative.
  - Otherwise ±max-finite (sZ,0xFE,0x7FFFFF).
- Underflow (E≤0 after rounding): udrf=1, ovrf=0, fp_Z=±0 (no subnormal outputs).
- Exact and inexact normal results: both flags 0. No inexact flag.

Decomposition:
- Package fp32_pkg:
  - rounding-mode enum (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4);
  - field widths (EXP_W=8, FRAC_W=23), BIAS=127;
  - constants QNAN=0x7FC00000, POS_INF=0x7F800000, MAX_FIN=0x7F7FFFFF.
- One natural sub-module: fp32_round. Inputs: sign, 24-bit mantissa, G/R/S, exponent, r_mode. Outputs: rounded mantissa/exponent and the overflow/underflow decision.
- Multiply, specials detection and output register live in the top level.

Test Plan:
- Basic product: fp_X=0x40B00000 (5.5), fp_Y=0xC0100000 (−2.25), r_mode=0 → next cycle fp_Z=0xC1460000 (−12.375), ovrf=0, udrf=0.
- Overflow: fp_X=0xF2A37F9E, fp_Y=0x6F18DA51.
  - r_mode=0 → fp_Z=0xFF800000, ovrf=1.
  - r_mode=1 → 0xFF7FFFFF, ovrf=1.
  - r_mode=3 → 0xFF7FFFFF, ovrf=1.
  - r_mode=2 → 0xFF800000, ovrf=1.
- Rounding modes: fp_X=fp_Y=0x3F800001.
  - r_mode=0 → 0x3F800002.
  - r_mode=1 → 0x3F800002.
  - r_mode=2 → 0x3F800002.
  - r_mode=3 → 0x3F800003.
  - r_mode=4 → 0x3F800002.
  - Flags 0 in all cases.
- Underflow: fp_X=0x00800000, fp_Y=0x3F000000 → fp_Z=0x00000000, udrf=1. Same with fp_Y=0xBF000000 → 0x80000000, udrf=1.
- Specials:
  - 0x00000000 × 0x40B00000 → 0x00000000.
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x7F800000 × 0xC0000000 → 0xFF800000.
  - 0x7FC00000 × 0x3F800000 → 0x7FC00000.
  - Flags 0 in all cases.
- Reset/pipeline:
  - Apply a back-to-back operand stream and check each result appears exactly one cycle later.
  - Assert rst_n low mid-stream → outputs go to 0 immediately, without waiting for a clock edge.
  - Release rst_n → the first sampled pair appears one cycle later.
